// File: rtl/viterbi_dec_if.sv
// Symbol-in / bit-out bundle for the Viterbi decoder.
// The master drives received symbols, the slave returns decoded bits.
interface viterbi_dec_if;
    logic [1:0] i_data;
    logic       i_valid;
    logic       o_data;
    logic       o_valid;

    modport master (
        output i_data,
        output i_valid,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/viterbi_dec.sv
// Hard-decision rate-1/2 Viterbi decoder, register-exchange survivors.
// All states run ACS in parallel; one decoded bit per symbol after D-1.
module viterbi_dec #(
    parameter int                        p_size_polinom  = 3,
    parameter logic [p_size_polinom-1:0] p_polinom_0     = 3'b111,
    parameter logic [p_size_polinom-1:0] p_polinom_1     = 3'b101,
    parameter logic [p_size_polinom-1:0] p_defoult_state = 3'b000,
    parameter int                        p_depth         = 16,
    parameter int                        p_metric_w      = 8,
    parameter int                        p_init_metric   = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    viterbi_dec_if.slave  bus
);
    localparam int K  = p_size_polinom;
    localparam int SW = K - 1;
    localparam int N  = 2 ** SW;
    localparam int D  = p_depth;
    localparam int MW = p_metric_w;
    localparam int CW = $clog2(D + 1);
    localparam int START = int'(p_defoult_state[K-2:0]);

    logic [MW-1:0] metric [N];
    logic [D-1:0]  path   [N];
    logic [MW-1:0] m_nxt  [N];
    logic [D-1:0]  p_nxt  [N];
    logic [CW-1:0] fill;
    logic          upd_q;
    logic [MW-1:0] m_min;
    logic [SW-1:0] s_best;

    function automatic logic [1:0] bmet(
        input logic [K-1:0] w,
        input logic [1:0]   rx
    );
        logic [1:0] d;
        d = {^(w & p_polinom_1), ^(w & p_polinom_0)} ^ rx;
        return {1'b0, d[0]} + {1'b0, d[1]};
    endfunction

    // lowest index wins ties, so only a strictly smaller metric moves it
    always_comb begin
        m_min  = metric[0];
        s_best = '0;
        for (int s = 1; s < N; s++) begin
            if (metric[s] < m_min) begin
                m_min  = metric[s];
                s_best = SW'(s);
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_acs
        localparam int P0 = g / 2;
        localparam int P1 = g / 2 + N / 2;
        localparam logic B = 1'(g % 2);
        localparam logic [K-1:0] W0 = K'(P0 * 2 + g % 2);
        localparam logic [K-1:0] W1 = K'(P1 * 2 + g % 2);

        logic [MW-1:0] c0;
        logic [MW-1:0] c1;
        logic          sel;

        assign c0  = metric[P0] + MW'(bmet(W0, bus.i_data));
        assign c1  = metric[P1] + MW'(bmet(W1, bus.i_data));
        assign sel = c1 < c0;

        assign m_nxt[g] = (sel ? c1 : c0) - m_min;
        assign p_nxt[g] = sel ? {path[P1][D-2:0], B}
                              : {path[P0][D-2:0], B};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < N; s++) begin
                metric[s] <= (s == START) ? '0 : MW'(p_init_metric);
                path[s]   <= '0;
            end
            fill        <= '0;
            upd_q       <= 1'b0;
            bus.o_data  <= 1'b0;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= upd_q;
            bus.o_data  <= path[s_best][D-1];
            upd_q       <= 1'b0;
            if (bus.i_valid) begin
                for (int s = 0; s < N; s++) begin
                    metric[s] <= m_nxt[s];
                    path[s]   <= p_nxt[s];
                end
                if (fill != CW'(D))
                    fill <= fill + 1'b1;
                upd_q <= fill >= CW'(D - 1);
            end
        end
    end
endmodule
